// File: rtl/nexys_starship_repair_ctrl.sv
// Room-repair responder: latches pseudo-random repair codes for broken rooms,
// runs per-room countdowns, checks submitted codes and raises a sticky game-over.
module nexys_starship_repair_ctrl #(
  parameter int TIMER_W = 30,
  parameter int TIMEOUT = 1_000_000_000,
  parameter int PENALTY = 100_000_000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               play_flag,
  input  logic [3:0]         break_req,
  input  logic [1:0]         sel_room,
  input  logic [3:0]         hex_combo,
  input  logic               submit,
  output logic [3:0]         broken,
  output logic [15:0]        repair_codes,
  output logic [TIMER_W-1:0] sel_time_left,
  output logic [3:0]         repaired,
  output logic               wrong,
  output logic               game_over_req
);
  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_FAIL} state_t;

  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);
  // A wrong code costs the penalty plus the normal one-cycle decrement.
  localparam logic [TIMER_W-1:0] PEN_STEP  = TIMER_W'(PENALTY + 1);

  state_t                 state_reg, state_next;
  logic [15:0]            lfsr_reg;
  logic [3:0]             new_code;
  logic                   active;
  logic [3:0]             ok, bad, expire;
  logic [4*TIMER_W-1:0]   timers_flat;
  logic [3:0]             repaired_reg;
  logic                   wrong_reg;

  assign active   = play_flag && (state_reg != S_FAIL);
  assign new_code = (lfsr_reg[3:0] == 4'h0) ? 4'h1 : lfsr_reg[3:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_room
      logic               broken_reg;
      logic [3:0]         code_reg;
      logic [TIMER_W-1:0] timer_reg;
      logic               is_sel;
      logic               brk;

      assign is_sel     = active && submit && (sel_room == 2'(gi));
      assign ok[gi]     = is_sel && broken_reg && (hex_combo == code_reg);
      assign bad[gi]    = is_sel && broken_reg && (hex_combo != code_reg);
      // Break on a working room only; submit sees the pre-break state.
      assign brk        = active && break_req[gi] && !broken_reg;
      assign expire[gi] = active && broken_reg && (timer_reg == '0) && !ok[gi];

      always_ff @(posedge Clk) begin
        if (Reset) begin
          broken_reg <= 1'b0;
          code_reg   <= 4'h0;
          timer_reg  <= '0;
        end else if (ok[gi]) begin
          broken_reg <= 1'b0;
          code_reg   <= 4'h0;
          timer_reg  <= '0;
        end else if (brk) begin
          broken_reg <= 1'b1;
          code_reg   <= new_code;
          timer_reg  <= TIMEOUT_V;
        end else if (active && broken_reg) begin
          if (bad[gi]) begin
            timer_reg <= (timer_reg > PEN_STEP) ? timer_reg - PEN_STEP : '0;
          end else if (timer_reg != '0) begin
            timer_reg <= timer_reg - TIMER_W'(1);
          end
        end
      end

      assign broken[gi]                              = broken_reg;
      assign repair_codes[gi*4 +: 4]                 = code_reg;
      assign timers_flat[gi*TIMER_W +: TIMER_W]      = timer_reg;
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= S_RUN;
      repaired_reg <= 4'h0;
      wrong_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      repaired_reg <= ok;
      wrong_reg    <= |bad;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FAIL:  state_next = S_FAIL;
      default: begin
        if (|expire)        state_next = S_FAIL;
        else if (play_flag) state_next = S_RUN;
        else                state_next = S_PAUSE;
      end
    endcase
  end

  assign repaired      = repaired_reg;
  assign wrong         = wrong_reg;
  assign game_over_req = (state_reg == S_FAIL);
  assign sel_time_left = broken[sel_room] ? timers_flat[sel_room*TIMER_W +: TIMER_W] : '0;

endmodule

// File: tb/tb_nexys_starship_repair_ctrl.sv
// Directed bench for the room-repair responder (TIMEOUT=20, PENALTY=5, TIMER_W=8).
module tb_nexys_starship_repair_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        play_flag;
  logic [3:0]  break_req;
  logic [1:0]  sel_room;
  logic [3:0]  hex_combo;
  logic        submit;
  logic [3:0]  broken;
  logic [15:0] repair_codes;
  logic [7:0]  sel_time_left;
  logic [3:0]  repaired;
  logic        wrong;
  logic        game_over_req;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_lfsr;
  logic [3:0]  code0, code1, code2, code3;

  nexys_starship_repair_ctrl #(.TIMER_W(8), .TIMEOUT(20), .PENALTY(5)) dut (
    .Clk(clk), .Reset(rst), .play_flag(play_flag), .break_req(break_req),
    .sel_room(sel_room), .hex_combo(hex_combo), .submit(submit),
    .broken(broken), .repair_codes(repair_codes), .sel_time_left(sel_time_left),
    .repaired(repaired), .wrong(wrong), .game_over_req(game_over_req)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [3:0] nz(input logic [3:0] x);
    return (x == 4'h0) ? 4'h1 : x;
  endfunction

  // Reference LFSR: value read between edges is the one the DUT uses at the next edge.
  always @(posedge clk) model_lfsr <= rst ? 16'hACE1 : lfsr_step(model_lfsr);

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; play_flag = 1'b1; break_req = 4'h0; sel_room = 2'd0;
    hex_combo = 4'h0; submit = 1'b0;
    tick(3);
    check("rst_broken", 32'(broken), 0);
    check("rst_codes", 32'(repair_codes), 0);
    check("rst_time", 32'(sel_time_left), 0);
    check("rst_repaired", 32'(repaired), 0);
    check("rst_wrong", 32'(wrong), 0);
    check("rst_gameover", 32'(game_over_req), 0);
    rst = 1'b0;
    tick(2);

    // Break room 0, then repair it three cycles later.
    code0 = nz(model_lfsr[3:0]);
    sel_room = 2'd0; break_req = 4'b0001;
    tick(); break_req = 4'h0;
    check("brk0_broken", 32'(broken), 32'b0001);
    check("brk0_code", 32'(repair_codes), 32'(code0));
    check("brk0_time", 32'(sel_time_left), 20);
    tick(2);
    check("brk0_time18", 32'(sel_time_left), 18);
    hex_combo = code0; submit = 1'b1;
    tick(); submit = 1'b0;
    check("rep0_pulse", 32'(repaired), 32'b0001);
    check("rep0_broken", 32'(broken), 0);
    check("rep0_codes", 32'(repair_codes), 0);
    check("rep0_wrong", 32'(wrong), 0);
    tick();
    check("rep0_pulse_end", 32'(repaired), 0);

    // Wrong code on room 2 at timer 12, then correct code.
    code2 = nz(model_lfsr[3:0]);
    sel_room = 2'd2; break_req = 4'b0100;
    tick(); break_req = 4'h0;
    check("brk2_code", 32'(repair_codes), 32'(code2) << 8);
    tick(8);
    check("brk2_time12", 32'(sel_time_left), 12);
    hex_combo = code2 ^ 4'hF; submit = 1'b1;
    tick(); submit = 1'b0;
    check("wrong2_pulse", 32'(wrong), 1);
    check("wrong2_time", 32'(sel_time_left), 6);
    check("wrong2_broken", 32'(broken), 32'b0100);
    check("wrong2_norep", 32'(repaired), 0);
    tick();
    check("wrong2_pulse_end", 32'(wrong), 0);
    check("wrong2_time5", 32'(sel_time_left), 5);
    hex_combo = code2; submit = 1'b1;
    tick(); submit = 1'b0;
    check("rep2_pulse", 32'(repaired), 32'b0100);
    check("rep2_broken", 32'(broken), 0);

    // Pause with room 1 broken: frozen timer, ignored submit and break.
    code1 = nz(model_lfsr[3:0]);
    sel_room = 2'd1; break_req = 4'b0010;
    tick(); break_req = 4'h0;
    tick();
    check("brk1_time19", 32'(sel_time_left), 19);
    play_flag = 1'b0;
    tick(4);
    hex_combo = code1; submit = 1'b1; break_req = 4'b0001;
    tick(); submit = 1'b0; break_req = 4'h0;
    check("pause_norep", 32'(repaired), 0);
    check("pause_broken", 32'(broken), 32'b0010);
    tick(5);
    check("pause_time", 32'(sel_time_left), 19);
    play_flag = 1'b1;
    tick();
    check("resume_time", 32'(sel_time_left), 18);
    submit = 1'b1;
    tick(); submit = 1'b0;
    check("rep1_pulse", 32'(repaired), 32'b0010);

    // Submit and break on the same working room: submit ignored, break taken.
    code2 = nz(model_lfsr[3:0]);
    sel_room = 2'd2; hex_combo = 4'h0; submit = 1'b1; break_req = 4'b0100;
    tick(); submit = 1'b0; break_req = 4'h0;
    check("sim_wrong", 32'(wrong), 0);
    check("sim_broken", 32'(broken), 32'b0100);
    hex_combo = code2; submit = 1'b1;
    tick(); submit = 1'b0;
    check("rep2b_pulse", 32'(repaired), 32'b0100);

    // Room 0: repeated break ignored; correct submit at timer 0 beats FAIL.
    code0 = nz(model_lfsr[3:0]);
    sel_room = 2'd0; break_req = 4'b0001;
    tick(); break_req = 4'h0;
    tick(5);
    check("dup_time15", 32'(sel_time_left), 15);
    break_req = 4'b0001;
    tick(); break_req = 4'h0;
    check("dup_code", 32'(repair_codes), 32'(code0));
    check("dup_time", 32'(sel_time_left), 14);
    tick(14);
    check("t0_time", 32'(sel_time_left), 0);
    check("t0_gameover", 32'(game_over_req), 0);
    hex_combo = code0; submit = 1'b1;
    tick(); submit = 1'b0;
    check("t0_rep", 32'(repaired), 32'b0001);
    check("t0_broken", 32'(broken), 0);
    tick();
    check("t0_no_fail", 32'(game_over_req), 0);

    // Room 3 left alone: FAIL at the 22nd edge counting the break edge as 1.
    code3 = nz(model_lfsr[3:0]);
    sel_room = 2'd3; break_req = 4'b1000;
    tick(); break_req = 4'h0;
    tick(20);
    check("to_time0", 32'(sel_time_left), 0);
    check("to_not_yet", 32'(game_over_req), 0);
    tick();
    check("to_gameover", 32'(game_over_req), 1);
    hex_combo = code3; submit = 1'b1; break_req = 4'b0001;
    tick(); submit = 1'b0; break_req = 4'h0;
    check("fail_norep", 32'(repaired), 0);
    check("fail_nowrong", 32'(wrong), 0);
    check("fail_frozen", 32'(broken), 32'b1000);
    check("fail_code", 32'(repair_codes), 32'(code3) << 12);
    check("fail_sticky", 32'(game_over_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_gameover", 32'(game_over_req), 0);
    check("rst2_broken", 32'(broken), 0);
    check("rst2_codes", 32'(repair_codes), 0);
    tick();
    check("rst2_stay", 32'(game_over_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
